lc3_ctrl_seq: RTL and testbench

- Parametrised LC-3 instruction sequencer; the control FSM of the Lab 6 datapath.
- Drives the load enables, bus gates, mux selects and SRAM strobes consumed by the existing datapath.
- Over the previous sequencer it adds:
  - configurable SRAM wait states (one shared wait counter);
  - LEA, LDI and STI;
  - an optional PAUSE instruction;
  - a debug state output.

---
 rtl/lc3_ctrl_seq.sv | 208 ++++++++++++++++++++
 tb/tb_lc3_ctrl_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_ctrl_seq.sv
// LC-3 instruction sequencer: fetch/decode/execute control FSM for the Lab 6 datapath.
// Outputs are combinational from the current state; SRAM states last exactly MEM_WAIT cycles.
// Run is sampled only in HALTED; PAUSE waits for a full Continue high/low handshake.
module lc3_ctrl_seq #(
  parameter int MEM_WAIT = 2,
  parameter int PAUSE_EN = 1,
  parameter int STATE_W  = 5
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Run,
  input  logic               Continue,
  input  logic [3:0]         Opcode,
  input  logic               IR_5,
  input  logic               IR_11,
  input  logic               BEN,
  output logic               LD_MAR,
  output logic               LD_MDR,
  output logic               LD_IR,
  output logic               LD_BEN,
  output logic               LD_CC,
  output logic               LD_REG,
  output logic               LD_PC,
  output logic               LD_LED,
  output logic               GatePC,
  output logic               GateMDR,
  output logic               GateALU,
  output logic               GateMARMUX,
  output logic [1:0]         PCMUX,
  output logic               DRMUX,
  output logic               SR1MUX,
  output logic               SR2MUX,
  output logic               ADDR1MUX,
  output logic [1:0]         ADDR2MUX,
  output logic [1:0]         ALUK,
  output logic               Mem_CE,
  output logic               Mem_UB,
  output logic               Mem_LB,
  output logic               Mem_OE,
  output logic               Mem_WE,
  output logic [STATE_W-1:0] Dbg_State
);

  typedef enum logic [4:0] {
    S_HALTED, S_F_MAR, S_F_RD, S_F_IR, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_T, S_JMP, S_JSR_LINK, S_JSR_PC, S_LEA,
    S_LDR_A, S_LDI_A, S_LDI_RD, S_LDI_MAR, S_LD_RD, S_LD_WB,
    S_STR_A, S_STI_A, S_STI_RD, S_STI_MAR, S_ST_MDR, S_ST_WR,
    S_PAUSE1, S_PAUSE2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic       mem_state;
  logic       wait_done;

  assign mem_state = (state == S_F_RD)   || (state == S_LDI_RD) || (state == S_LD_RD) ||
                     (state == S_STI_RD) || (state == S_ST_WR);
  assign wait_done = (wait_cnt == WAIT_LAST);

  assign Mem_CE    = 1'b0;
  assign Mem_UB    = 1'b0;
  assign Mem_LB    = 1'b0;
  assign Dbg_State = STATE_W'(state);

  // State register; reset lands in HALTED regardless of any access in flight.
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_HALTED;
    else       state <= state_nxt;
  end

  // Shared wait counter: counts only inside a memory state and is zero elsewhere,
  // so every access starts from 0 on entry.
  always_ff @(posedge Clk) begin
    if (Reset || !mem_state || wait_done) wait_cnt <= '0;
    else                                  wait_cnt <= wait_cnt + 4'd1;
  end

  // Next-state and control outputs; Reset forces every output to its idle value.
  always_comb begin
    state_nxt  = state;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    if (!Reset) begin
      case (state)
        S_HALTED: if (Run) state_nxt = S_F_MAR;
        S_F_MAR: begin
          GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = 2'b10; LD_PC = 1'b1;
          state_nxt = S_F_RD;
        end
        S_F_RD: begin
          Mem_OE = 1'b0;
          if (wait_done) begin LD_MDR = 1'b1; state_nxt = S_F_IR; end
        end
        S_F_IR: begin
          GateMDR = 1'b1; LD_IR = 1'b1;
          state_nxt = S_DECODE;
        end
        S_DECODE: begin
          LD_BEN = 1'b1;
          case (Opcode)
            4'b0001: state_nxt = S_ADD;
            4'b0101: state_nxt = S_AND;
            4'b1001: state_nxt = S_NOT;
            4'b0000: state_nxt = S_BR;
            4'b1100: state_nxt = S_JMP;
            4'b0100: state_nxt = S_JSR_LINK;
            4'b1110: state_nxt = S_LEA;
            4'b0110: state_nxt = S_LDR_A;
            4'b1010: state_nxt = S_LDI_A;
            4'b0111: state_nxt = S_STR_A;
            4'b1011: state_nxt = S_STI_A;
            4'b1101: state_nxt = (PAUSE_EN != 0) ? S_PAUSE1 : S_F_MAR;
            default: state_nxt = S_F_MAR;
          endcase
        end
        S_ADD, S_AND, S_NOT: begin
          GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; SR1MUX = 1'b1; SR2MUX = IR_5;
          ALUK = (state == S_ADD) ? 2'b00 : (state == S_AND) ? 2'b01 : 2'b11;
          state_nxt = S_F_MAR;
        end
        S_BR: state_nxt = BEN ? S_BR_T : S_F_MAR;
        S_BR_T: begin
          LD_PC = 1'b1; PCMUX = 2'b01; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01;
          state_nxt = S_F_MAR;
        end
        S_JMP: begin
          SR1MUX = 1'b1; ALUK = 2'b10; GateALU = 1'b1; PCMUX = 2'b00; LD_PC = 1'b1;
          state_nxt = S_F_MAR;
        end
        S_JSR_LINK: begin
          GatePC = 1'b1; DRMUX = 1'b1; LD_REG = 1'b1;
          state_nxt = S_JSR_PC;
        end
        S_JSR_PC: begin
          LD_PC = 1'b1; PCMUX = 2'b01;
          if (IR_11) begin ADDR1MUX = 1'b1; ADDR2MUX = 2'b00; end
          else       begin SR1MUX = 1'b1;   ADDR2MUX = 2'b11; end
          state_nxt = S_F_MAR;
        end
        S_LEA: begin
          GateMARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; LD_REG = 1'b1; LD_CC = 1'b1;
          state_nxt = S_F_MAR;
        end
        S_LDR_A, S_STR_A: begin
          GateMARMUX = 1'b1; ADDR2MUX = 2'b10; SR1MUX = 1'b1; LD_MAR = 1'b1;
          state_nxt = (state == S_LDR_A) ? S_LD_RD : S_ST_MDR;
        end
        S_LDI_A, S_STI_A: begin
          GateMARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = 2'b01; LD_MAR = 1'b1;
          state_nxt = (state == S_LDI_A) ? S_LDI_RD : S_STI_RD;
        end
        S_LDI_RD, S_STI_RD, S_LD_RD: begin
          Mem_OE = 1'b0;
          if (wait_done) begin
            LD_MDR = 1'b1;
            state_nxt = (state == S_LDI_RD) ? S_LDI_MAR :
                        (state == S_STI_RD) ? S_STI_MAR : S_LD_WB;
          end
        end
        S_LDI_MAR, S_STI_MAR: begin
          GateMDR = 1'b1; LD_MAR = 1'b1;
          state_nxt = (state == S_LDI_MAR) ? S_LD_RD : S_ST_MDR;
        end
        S_LD_WB: begin
          GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; DRMUX = 1'b0;
          state_nxt = S_F_MAR;
        end
        S_ST_MDR: begin
          SR1MUX = 1'b0; ALUK = 2'b10; GateALU = 1'b1; LD_MDR = 1'b1;
          state_nxt = S_ST_WR;
        end
        S_ST_WR: begin
          Mem_WE = 1'b0;
          if (wait_done) state_nxt = S_F_MAR;
        end
        S_PAUSE1: begin
          LD_LED = 1'b1;
          if (Continue) state_nxt = S_PAUSE2;
        end
        S_PAUSE2: if (!Continue) state_nxt = S_F_MAR;
        default: state_nxt = S_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_ctrl_seq.sv
// Bench for lc3_ctrl_seq: three instances with different wait/pause settings.
// Expected control words come from per-instruction micro-step tables.
// Each cycle the full 27-bit output word of the active instance is compared.
module tb_lc3_ctrl_seq;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [2:0]  rst, run, cont, ir5, ir11, ben;
  logic [3:0]  opc [3];
  logic [26:0] cw0, cw1, cw2;
  logic [4:0]  dbg0, dbg1, dbg2;
  logic [4:0]  hd [3];
  int          checks, passed, fails;
  logic [26:0] exp_q [$];

  // Output word layout: {loads(8), gates(4), PCMUX, DRMUX, SR1, SR2, ADDR1, ADDR2, ALUK, CE, UB, LB, OE, WE}
  localparam logic [26:0] IDLE   = 27'h3;
  localparam logic [26:0] RDW    = 27'h1;
  localparam logic [26:0] WRW    = 27'h2;
  localparam logic [26:0] LDMAR  = 27'd1 << 26;
  localparam logic [26:0] LDMDR  = 27'd1 << 25;
  localparam logic [26:0] LDIR   = 27'd1 << 24;
  localparam logic [26:0] LDBEN  = 27'd1 << 23;
  localparam logic [26:0] LDCC   = 27'd1 << 22;
  localparam logic [26:0] LDREG  = 27'd1 << 21;
  localparam logic [26:0] LDPC   = 27'd1 << 20;
  localparam logic [26:0] LDLED  = 27'd1 << 19;
  localparam logic [26:0] GPC    = 27'd1 << 18;
  localparam logic [26:0] GMDR   = 27'd1 << 17;
  localparam logic [26:0] GALU   = 27'd1 << 16;
  localparam logic [26:0] GMARMX = 27'd1 << 15;
  localparam logic [26:0] DRM    = 27'd1 << 12;
  localparam logic [26:0] SR1    = 27'd1 << 11;
  localparam logic [26:0] SR2    = 27'd1 << 10;
  localparam logic [26:0] AD1    = 27'd1 << 9;

  function automatic logic [26:0] pcm(input int v);  return 27'(v) << 13; endfunction
  function automatic logic [26:0] ad2(input int v);  return 27'(v) << 7;  endfunction
  function automatic logic [26:0] aluk(input int v); return 27'(v) << 5;  endfunction

  function automatic int mw(input int k); return (k == 0) ? 2 : (k == 1) ? 4 : 3; endfunction
  function automatic bit pe(input int k); return (k != 2); endfunction

  function automatic logic [26:0] obs(input int k);
    case (k)
      0:       return cw0;
      1:       return cw1;
      default: return cw2;
    endcase
  endfunction

  function automatic logic [4:0] dbgv(input int k);
    case (k)
      0:       return dbg0;
      1:       return dbg1;
      default: return dbg2;
    endcase
  endfunction

  lc3_ctrl_seq #(.MEM_WAIT(2), .PAUSE_EN(1), .STATE_W(5)) u_a (
    .Clk(Clk), .Reset(rst[0]), .Run(run[0]), .Continue(cont[0]), .Opcode(opc[0]),
    .IR_5(ir5[0]), .IR_11(ir11[0]), .BEN(ben[0]),
    .LD_MAR(cw0[26]), .LD_MDR(cw0[25]), .LD_IR(cw0[24]), .LD_BEN(cw0[23]), .LD_CC(cw0[22]),
    .LD_REG(cw0[21]), .LD_PC(cw0[20]), .LD_LED(cw0[19]), .GatePC(cw0[18]), .GateMDR(cw0[17]),
    .GateALU(cw0[16]), .GateMARMUX(cw0[15]), .PCMUX(cw0[14:13]), .DRMUX(cw0[12]),
    .SR1MUX(cw0[11]), .SR2MUX(cw0[10]), .ADDR1MUX(cw0[9]), .ADDR2MUX(cw0[8:7]), .ALUK(cw0[6:5]),
    .Mem_CE(cw0[4]), .Mem_UB(cw0[3]), .Mem_LB(cw0[2]), .Mem_OE(cw0[1]), .Mem_WE(cw0[0]),
    .Dbg_State(dbg0));

  lc3_ctrl_seq #(.MEM_WAIT(4), .PAUSE_EN(1), .STATE_W(5)) u_b (
    .Clk(Clk), .Reset(rst[1]), .Run(run[1]), .Continue(cont[1]), .Opcode(opc[1]),
    .IR_5(ir5[1]), .IR_11(ir11[1]), .BEN(ben[1]),
    .LD_MAR(cw1[26]), .LD_MDR(cw1[25]), .LD_IR(cw1[24]), .LD_BEN(cw1[23]), .LD_CC(cw1[22]),
    .LD_REG(cw1[21]), .LD_PC(cw1[20]), .LD_LED(cw1[19]), .GatePC(cw1[18]), .GateMDR(cw1[17]),
    .GateALU(cw1[16]), .GateMARMUX(cw1[15]), .PCMUX(cw1[14:13]), .DRMUX(cw1[12]),
    .SR1MUX(cw1[11]), .SR2MUX(cw1[10]), .ADDR1MUX(cw1[9]), .ADDR2MUX(cw1[8:7]), .ALUK(cw1[6:5]),
    .Mem_CE(cw1[4]), .Mem_UB(cw1[3]), .Mem_LB(cw1[2]), .Mem_OE(cw1[1]), .Mem_WE(cw1[0]),
    .Dbg_State(dbg1));

  lc3_ctrl_seq #(.MEM_WAIT(3), .PAUSE_EN(0), .STATE_W(5)) u_c (
    .Clk(Clk), .Reset(rst[2]), .Run(run[2]), .Continue(cont[2]), .Opcode(opc[2]),
    .IR_5(ir5[2]), .IR_11(ir11[2]), .BEN(ben[2]),
    .LD_MAR(cw2[26]), .LD_MDR(cw2[25]), .LD_IR(cw2[24]), .LD_BEN(cw2[23]), .LD_CC(cw2[22]),
    .LD_REG(cw2[21]), .LD_PC(cw2[20]), .LD_LED(cw2[19]), .GatePC(cw2[18]), .GateMDR(cw2[17]),
    .GateALU(cw2[16]), .GateMARMUX(cw2[15]), .PCMUX(cw2[14:13]), .DRMUX(cw2[12]),
    .SR1MUX(cw2[11]), .SR2MUX(cw2[10]), .ADDR1MUX(cw2[9]), .ADDR2MUX(cw2[8:7]), .ALUK(cw2[6:5]),
    .Mem_CE(cw2[4]), .Mem_UB(cw2[3]), .Mem_LB(cw2[2]), .Mem_OE(cw2[1]), .Mem_WE(cw2[0]),
    .Dbg_State(dbg2));

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic step(input int k, input logic [26:0] e, input string tag);
    @(negedge Clk);
    check(tag, 32'(obs(k)), 32'(e));
    tick();
  endtask

  // One SRAM access: MEM_WAIT cycles of strobe, MDR loaded on the last read cycle.
  function automatic void add_access(input int k, input bit write);
    for (int i = 0; i < mw(k); i++) begin
      if (write) exp_q.push_back(WRW);
      else       exp_q.push_back(RDW | ((i == mw(k) - 1) ? LDMDR : 27'd0));
    end
  endfunction

  task automatic pause_seq(input int k, input int hold, input int n2);
    for (int i = 0; i < hold; i++) begin
      cont[k] = 1'b0;
      step(k, IDLE | LDLED, $sformatf("k%0d pause1 wait %0d", k, i));
    end
    cont[k] = 1'b1;
    step(k, IDLE | LDLED, $sformatf("k%0d pause1 release", k));
    for (int i = 0; i < n2; i++) begin
      cont[k] = 1'b1;
      step(k, IDLE, $sformatf("k%0d pause2 hold %0d", k, i));
    end
    cont[k] = 1'b0;
    step(k, IDLE, $sformatf("k%0d pause2 exit", k));
  endtask

  // Runs one instruction starting at its F_MAR cycle; cut >= 0 stops after that many cycles.
  task automatic run_instr(input int k, input logic [3:0] op, input logic i5, input logic i11,
                           input logic b, input int hold, input int n2, input int cut, input bit dchk);
    int n;
    opc[k] = op; ir5[k] = i5; ir11[k] = i11; ben[k] = b;
    exp_q.delete();
    exp_q.push_back(IDLE | LDMAR | GPC | LDPC | pcm(2));
    add_access(k, 1'b0);
    exp_q.push_back(IDLE | GMDR | LDIR);
    exp_q.push_back(IDLE | LDBEN);
    case (op)
      4'b0001: exp_q.push_back(IDLE | GALU | LDREG | LDCC | SR1 | (i5 ? SR2 : 27'd0) | aluk(0));
      4'b0101: exp_q.push_back(IDLE | GALU | LDREG | LDCC | SR1 | (i5 ? SR2 : 27'd0) | aluk(1));
      4'b1001: exp_q.push_back(IDLE | GALU | LDREG | LDCC | SR1 | (i5 ? SR2 : 27'd0) | aluk(3));
      4'b0000: begin
        exp_q.push_back(IDLE);
        if (b) exp_q.push_back(IDLE | LDPC | pcm(1) | AD1 | ad2(1));
      end
      4'b1100: exp_q.push_back(IDLE | SR1 | aluk(2) | GALU | pcm(0) | LDPC);
      4'b0100: begin
        exp_q.push_back(IDLE | GPC | DRM | LDREG);
        if (i11) exp_q.push_back(IDLE | LDPC | pcm(1) | AD1 | ad2(0));
        else     exp_q.push_back(IDLE | LDPC | pcm(1) | SR1 | ad2(3));
      end
      4'b1110: exp_q.push_back(IDLE | GMARMX | AD1 | ad2(1) | LDREG | LDCC);
      4'b0110: begin
        exp_q.push_back(IDLE | GMARMX | ad2(2) | SR1 | LDMAR);
        add_access(k, 1'b0);
        exp_q.push_back(IDLE | GMDR | LDREG | LDCC);
      end
      4'b1010: begin
        exp_q.push_back(IDLE | GMARMX | AD1 | ad2(1) | LDMAR);
        add_access(k, 1'b0);
        exp_q.push_back(IDLE | GMDR | LDMAR);
        add_access(k, 1'b0);
        exp_q.push_back(IDLE | GMDR | LDREG | LDCC);
      end
      4'b0111: begin
        exp_q.push_back(IDLE | GMARMX | ad2(2) | SR1 | LDMAR);
        exp_q.push_back(IDLE | aluk(2) | GALU | LDMDR);
        add_access(k, 1'b1);
      end
      4'b1011: begin
        exp_q.push_back(IDLE | GMARMX | AD1 | ad2(1) | LDMAR);
        add_access(k, 1'b0);
        exp_q.push_back(IDLE | GMDR | LDMAR);
        exp_q.push_back(IDLE | aluk(2) | GALU | LDMDR);
        add_access(k, 1'b1);
      end
      default: ;
    endcase
    n = (cut >= 0) ? cut : exp_q.size();
    for (int i = 0; i < n; i++) begin
      run[k]  = 1'($urandom_range(0, 1));
      cont[k] = 1'($urandom_range(0, 1));
      if (dchk && i == 0) begin
        @(negedge Clk);
        check($sformatf("k%0d op%b c0", k, op), 32'(obs(k)), 32'(exp_q[0]));
        check($sformatf("k%0d dbg left halted", k), 32'(dbgv(k) !== hd[k]), 32'd1);
        tick();
      end else begin
        step(k, exp_q[i], $sformatf("k%0d op%b c%0d", k, op, i));
      end
    end
    if (cut < 0 && op == 4'b1101 && pe(k)) pause_seq(k, hold, n2);
  endtask

  task automatic start(input int k);
    run[k] = 1'b1;
    step(k, IDLE, $sformatf("k%0d halted run", k));
  endtask

  task automatic park(input int k);
    rst[k] = 1'b1; run[k] = 1'b0;
    step(k, IDLE, $sformatf("k%0d park reset", k));
    rst[k] = 1'b0;
    step(k, IDLE, $sformatf("k%0d park halted", k));
  endtask

  task automatic random_instrs(input int k, input int count);
    for (int i = 0; i < count; i++)
      run_instr(k, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3), -1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; passed = 0; fails = 0;
    rst = 3'b111; run = 3'b111; cont = '0; ir5 = '0; ir11 = '0; ben = '0;
    for (int k = 0; k < 3; k++) opc[k] = 4'b0001;

    // Reset cycle: everything idle even with Run high.
    @(negedge Clk);
    for (int k = 0; k < 3; k++) check($sformatf("k%0d in reset", k), 32'(obs(k)), 32'(IDLE));
    tick();
    rst = '0; run = '0;
    @(negedge Clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("k%0d after reset", k), 32'(obs(k)), 32'(IDLE));
      hd[k] = dbgv(k);
    end
    tick();
    @(negedge Clk);
    for (int k = 0; k < 3; k++) check($sformatf("k%0d halted holds", k), 32'(dbgv(k)), 32'(hd[k]));
    tick();

    // Instance A: MEM_WAIT=2, PAUSE enabled.
    start(0);
    run_instr(0, 4'b0001, 1'b1, 1'b0, 1'b0, 0, 0, -1, 1'b1);
    run_instr(0, 4'b0000, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(0, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 0, -1, 1'b0);
    run_instr(0, 4'b1100, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(0, 4'b0100, 1'b0, 1'b1, 1'b0, 0, 0, -1, 1'b0);
    run_instr(0, 4'b0100, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(0, 4'b1110, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(0, 4'b0101, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(0, 4'b1001, 1'b1, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(0, 4'b0110, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(0, 4'b0111, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(0, 4'b1101, 1'b0, 1'b0, 1'b0, 10, 1, -1, 1'b0);
    run_instr(0, 4'b1101, 1'b0, 1'b0, 1'b0, 0, 2, -1, 1'b0);
    run_instr(0, 4'b1000, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    random_instrs(0, 40);
    park(0);

    // Instance B: MEM_WAIT=4.
    start(1);
    run_instr(1, 4'b1010, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b1);
    random_instrs(1, 30);
    park(1);

    // Instance C: MEM_WAIT=3, PAUSE disabled.
    start(2);
    run_instr(2, 4'b1011, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b1);
    run_instr(2, 4'b1101, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    run_instr(2, 4'b1011, 1'b0, 1'b0, 1'b0, 0, 0, 13, 1'b0);
    rst[2] = 1'b1; run[2] = 1'b0;
    step(2, IDLE, "k2 reset in st_wr");
    rst[2] = 1'b0;
    @(negedge Clk);
    check("k2 strobes after abort", 32'(obs(2)), 32'(IDLE));
    check("k2 dbg halted after abort", 32'(dbgv(2)), 32'(hd[2]));
    tick();
    start(2);
    run_instr(2, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 0, -1, 1'b0);
    random_instrs(2, 30);
    park(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
